// File: rtl/nor_netlist_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// nor_seq_pkg : shared types and constants for the NOR netlist sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package nor_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_N_IN    = 4;
  localparam int DEF_N_OUT   = 3;
  localparam int DEF_N_CELL  = 16;
  localparam int DEF_N_INSTR = 16;

  localparam int OUT_BASE = DEF_N_CELL - DEF_N_OUT;
  localparam int IN_LAST  = DEF_N_IN - 1;

  // Instruction word is {is_inv, src_a, src_b, dst}, each index AW bits wide.
  localparam int DST_LSB = 0;

  function automatic int src_b_lsb(input int aw);
    return aw;
  endfunction

  function automatic int src_a_lsb(input int aw);
    return 2 * aw;
  endfunction

  function automatic int inv_bit(input int aw);
    return 3 * aw;
  endfunction

  function automatic int out_base(input int n_cell, input int n_out);
    return n_cell - n_out;
  endfunction

  function automatic int in_last(input int n_in);
    return n_in - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nor_netlist_sequencer_if.sv
// ----------------------------------------------------------------------------
// nor_seq_if : host-side program/run interface of the NOR netlist sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface nor_seq_if #(
  parameter int N_IN    = 4,
  parameter int N_OUT   = 3,
  parameter int PW      = 4,
  parameter int INSTR_W = 13
);
  logic               cfg_we;
  logic [PW-1:0]      cfg_addr;
  logic [INSTR_W-1:0] cfg_data;
  logic [PW:0]        prog_len;
  logic               start;
  logic [N_IN-1:0]    in_vec;
  logic               busy;
  logic               done;
  logic [N_OUT-1:0]   out_vec;
  logic               err;

  modport master (
    output cfg_we, cfg_addr, cfg_data, prog_len, start, in_vec,
    input  busy, done, out_vec, err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, prog_len, start, in_vec,
    output busy, done, out_vec, err
  );
endinterface

`default_nettype wire

// File: rtl/nor_netlist_sequencer_cell_file.sv
// ----------------------------------------------------------------------------
// nor_cell_file : bit-cell register file, bulk load, 1 write / 2 read ports
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module nor_cell_file #(
  parameter int N_CELL = 16,
  parameter int AW     = $clog2(N_CELL)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en_i,
  input  logic [N_CELL-1:0] load_data_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic              wdata_i,
  input  logic [AW-1:0]     raddr_a_i,
  input  logic [AW-1:0]     raddr_b_i,
  output logic              rdata_a_o,
  output logic              rdata_b_o,
  output logic [N_CELL-1:0] cells_o
);

  logic [N_CELL-1:0] cells_q;

  // Out-of-range indices only exist for non-power-of-2 N_CELL: drop/read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cells_q <= '0;
    end else if (load_en_i) begin
      cells_q <= load_data_i;
    end else if (we_i && (int'(waddr_i) < N_CELL)) begin
      cells_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (int'(raddr_a_i) < N_CELL) ? cells_q[raddr_a_i] : 1'b0;
  assign rdata_b_o = (int'(raddr_b_i) < N_CELL) ? cells_q[raddr_b_i] : 1'b0;
  assign cells_o   = cells_q;

endmodule

`default_nettype wire

// File: rtl/nor_netlist_sequencer.sv
// ----------------------------------------------------------------------------
// nor_netlist_sequencer : runs a nor2/inv1 gate program on one NOR evaluator
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module nor_netlist_sequencer
  import nor_seq_pkg::*;
#(
  parameter int N_IN    = DEF_N_IN,
  parameter int N_OUT   = DEF_N_OUT,
  parameter int N_CELL  = DEF_N_CELL,
  parameter int N_INSTR = DEF_N_INSTR,
  parameter int AW      = $clog2(N_CELL),
  parameter int PW      = $clog2(N_INSTR),
  parameter int INSTR_W = 1 + 3 * AW
) (
  input  logic     clk,
  input  logic     rst_n,
  nor_seq_if.slave bus
);

  localparam int          C_OUT_BASE  = out_base(N_CELL, N_OUT);
  localparam int          C_IN_LAST   = in_last(N_IN);
  localparam int          C_INV_BIT   = inv_bit(AW);
  localparam int          C_SRC_A_LSB = src_a_lsb(AW);
  localparam int          C_SRC_B_LSB = src_b_lsb(AW);
  localparam logic [PW:0] C_MAX_LEN   = (PW+1)'(N_INSTR);

  state_t           state_q, state_d;
  logic [PW:0]      len_q, len_d;
  logic [PW-1:0]    pc_q, pc_d;
  logic [N_IN-1:0]  in_q, in_d;
  logic [N_OUT-1:0] out_q, out_d;
  logic             err_q, err_d;

  logic [INSTR_W-1:0] mem [N_INSTR];

  logic               w_busy;
  logic [INSTR_W-1:0] w_instr;
  logic               w_is_inv;
  logic [AW-1:0]      w_src_a, w_src_b, w_dst;
  logic               w_rd_a, w_rd_b, w_result;
  logic               w_dst_is_input;
  logic               w_cell_we;
  logic               w_load_en;
  logic [N_CELL-1:0]  w_load_data;
  logic [N_CELL-1:0]  w_cells;
  logic [N_CELL-1:0]  w_cells_nxt;

  assign w_busy = (state_q == LOAD) || (state_q == EXEC);

  always_ff @(posedge clk) begin
    if (bus.cfg_we && !w_busy && (int'(bus.cfg_addr) < N_INSTR)) begin
      mem[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  assign w_instr  = mem[pc_q];
  assign w_is_inv = w_instr[C_INV_BIT];
  assign w_src_a  = w_instr[C_SRC_A_LSB +: AW];
  assign w_src_b  = w_instr[C_SRC_B_LSB +: AW];
  assign w_dst    = w_instr[DST_LSB +: AW];

  assign w_result       = w_is_inv ? ~w_rd_a : ~(w_rd_a | w_rd_b);
  assign w_dst_is_input = (int'(w_dst) <= C_IN_LAST);
  assign w_cell_we      = (state_q == EXEC) && !w_dst_is_input;
  assign w_load_en      = (state_q == LOAD);

  for (genvar gi = 0; gi < N_CELL; gi++) begin : g_load
    if (gi < N_IN) begin : g_in
      assign w_load_data[gi] = in_q[gi];
    end else begin : g_zero
      assign w_load_data[gi] = 1'b0;
    end
  end

  nor_cell_file #(
    .N_CELL (N_CELL),
    .AW     (AW)
  ) u_cells (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_en_i   (w_load_en),
    .load_data_i (w_load_data),
    .we_i        (w_cell_we),
    .waddr_i     (w_dst),
    .wdata_i     (w_result),
    .raddr_a_i   (w_src_a),
    .raddr_b_i   (w_src_b),
    .rdata_a_o   (w_rd_a),
    .rdata_b_o   (w_rd_b),
    .cells_o     (w_cells)
  );

  // Cell contents as they will be after this edge, so out_vec is already
  // valid in the cycle done is raised (includes the last gate's write).
  always_comb begin
    w_cells_nxt = w_cells;
    if (w_load_en) begin
      w_cells_nxt = w_load_data;
    end else if (w_cell_we && (int'(w_dst) < N_CELL)) begin
      w_cells_nxt[w_dst] = w_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      pc_q    <= '0;
      in_q    <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pc_q    <= pc_d;
      in_q    <= in_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    pc_d    = pc_q;
    in_d    = in_q;
    out_d   = out_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD;
          len_d   = (bus.prog_len > C_MAX_LEN) ? C_MAX_LEN : bus.prog_len;
          in_d    = bus.in_vec;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        pc_d = '0;
        if (len_q != '0) begin
          state_d = EXEC;
        end else begin
          state_d = DONE;
          out_d   = w_cells_nxt[C_OUT_BASE +: N_OUT];
        end
      end
      EXEC: begin
        if (w_dst_is_input) begin
          err_d = 1'b1;
        end
        pc_d = pc_q + 1'b1;
        if ({1'b0, pc_q} == (len_q - 1'b1)) begin
          state_d = DONE;
          out_d   = w_cells_nxt[C_OUT_BASE +: N_OUT];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy    = w_busy;
  assign bus.done    = (state_q == DONE);
  assign bus.out_vec = out_q;
  assign bus.err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_nor_netlist_sequencer.sv
// ----------------------------------------------------------------------------
// tb_nor_netlist_sequencer : scoreboard bench for the NOR netlist sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_nor_netlist_sequencer;

  localparam int N_IN    = 4;
  localparam int N_OUT   = 3;
  localparam int N_CELL  = 16;
  localparam int N_INSTR = 16;
  localparam int PW      = 4;
  localparam int INSTR_W = 13;

  typedef struct {
    logic [N_OUT-1:0] out;
    logic             err;
    int               cyc;
    int               busy;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nor_seq_if #(.N_IN(N_IN), .N_OUT(N_OUT), .PW(PW), .INSTR_W(INSTR_W)) bus ();

  nor_netlist_sequencer #(
    .N_IN    (N_IN),
    .N_OUT   (N_OUT),
    .N_CELL  (N_CELL),
    .N_INSTR (N_INSTR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [INSTR_W-1:0] mk(input logic inv, input int a, input int b, input int d);
    return {inv, 4'(a), 4'(b), 4'(d)};
  endfunction

  task automatic wr(input int addr, input logic [INSTR_W-1:0] data);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = PW'(addr);
    bus.cfg_data = data;
  endtask

  task automatic wr_end();
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  // Full adder: x0-3 = cells 0..3, n1..n6 = 4..9, G5/G6/G7 = 13/14/15
  task automatic load_fa();
    wr(0, mk(0, 2, 3, 5));
    wr(1, mk(0, 0, 1, 4));
    wr(2, mk(0, 4, 5, 7));
    wr(3, mk(0, 1, 2, 6));
    wr(4, mk(1, 7, 0, 8));
    wr(5, mk(0, 6, 8, 9));
    wr(6, mk(0, 1, 5, 13));
    wr(7, mk(0, 5, 9, 14));
    wr(8, mk(0, 3, 9, 15));
    wr_end();
  endtask

  task automatic run_start(input int len, input logic [N_IN-1:0] vin,
                           input logic [N_OUT-1:0] eo, input logic ee);
    exp_t e;
    @(negedge clk);
    bus.prog_len = 5'(len);
    bus.in_vec   = vin;
    bus.start    = 1'b1;
    e.out  = eo;
    e.err  = ee;
    e.cyc  = cyc + 2 + len;
    e.busy = len + 1;
    sb_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL done_timeout: got no done expected done within 100 cycles");
  endtask

  task automatic run(input int len, input logic [N_IN-1:0] vin,
                     input logic [N_OUT-1:0] eo, input logic ee);
    run_start(len, vin, eo, ee);
    wait_done();
  endtask

  initial begin : monitor
    int   busy_cnt;
    exp_t e;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt = 0;
      end else begin
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.done === 1'b1) begin
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
          end else begin
            e = sb_q.pop_front();
            chk("out_vec", int'(bus.out_vec), int'(e.out));
            chk("err", int'(bus.err), int'(e.err));
            chk("done_cycle", cyc, e.cyc);
            chk("busy_cycles", busy_cnt, e.busy);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    exp_t dropped;
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    bus.prog_len = '0;
    bus.start    = 1'b0;
    bus.in_vec   = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_out_vec", int'(bus.out_vec), 0);
    chk("rst_err", int'(bus.err), 0);
    rst_n = 1'b1;

    load_fa();
    run(9, 4'b0000, 3'b100, 1'b0);
    run(9, 4'b1111, 3'b000, 1'b0);
    run(9, 4'b0101, 3'b001, 1'b0);

    run(0, 4'hF, 3'b000, 1'b0);

    // Start pulses and a program write during EXEC must both be ignored.
    run_start(9, 4'b0000, 3'b100, 1'b0);
    repeat (3) @(negedge clk);
    bus.start    = 1'b1;
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = '0;
    bus.cfg_data = 13'h1FFF;
    chk("busy_in_exec", int'(bus.busy), 1);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cfg_we = 1'b0;
    wait_done();
    run(9, 4'b0000, 3'b100, 1'b0);

    // Back-to-back; out_vec holds the previous result meanwhile.
    run(9, 4'b1111, 3'b000, 1'b0);
    run_start(9, 4'b0000, 3'b100, 1'b0);
    repeat (3) @(negedge clk);
    chk("out_hold", int'(bus.out_vec), 3'b000);
    wait_done();

    // Asynchronous reset in the middle of EXEC.
    run_start(9, 4'b0101, 3'b001, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    chk("midrst_out_vec", int'(bus.out_vec), 0);
    dropped = sb_q.pop_back();
    @(negedge clk);
    rst_n = 1'b1;
    run(9, 4'b0101, 3'b001, 1'b0);

    // Write to input cell 2 is suppressed and flags err.
    wr(0, mk(0, 0, 1, 2));
    wr(1, mk(1, 2, 0, 13));
    wr(2, mk(0, 0, 1, 14));
    wr(3, mk(1, 14, 0, 15));
    wr_end();
    run(4, 4'b0000, 3'b011, 1'b1);
    chk("err_sticky", int'(bus.err), 1);

    load_fa();
    run_start(9, 4'b1111, 3'b000, 1'b0);
    chk("err_cleared", int'(bus.err), 0);
    wait_done();

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nor_netlist_sequencer.md
Name: nor_netlist_sequencer

Overview:
Sequences a mapped NOR/INV netlist on one shared NOR evaluator, one gate per cycle, over a small bit-cell register file.
- A host writes a gate program, then pulses start with an input vector.
- The block loads inputs into cells, executes the gates in program order and returns the output cells.
- It sits between the mapping flow's gate list and the shared single-gate NOR datapath, so any nor2/inv1 netlist up to N_INSTR gates can be evaluated on one unit.

Parameters:
N_IN, 4, number of primary inputs; preloaded into cells 0..N_IN-1
N_OUT, 3, number of outputs; read from cells N_CELL-N_OUT..N_CELL-1
N_CELL, 16, number of bit cells
N_INSTR, 16, program memory depth
AW, $clog2(N_CELL), cell index width
PW, $clog2(N_INSTR), program address width
INSTR_W, 1+3*AW, instruction width; fields {is_inv, src_a, src_b, dst} from MSB to LSB

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  program write strobe; ignored when busy=1
cfg_addr  in  PW  program slot index
cfg_data  in  INSTR_W  instruction word
prog_len  in  PW+1  gate count, 0..N_INSTR; sampled when start is accepted
start  in  1  run request; accepted only in IDLE
in_vec  in  N_IN  primary inputs; sampled when start is accepted
busy  out  1  high in LOAD and EXEC
done  out  1  one-cycle pulse when the result is valid
out_vec  out  N_OUT  out_vec[k] = cell[N_CELL-N_OUT+k]; held until the next done
err  out  1  sticky flag: a write to an input cell was suppressed; cleared on start accept

Behaviour:
Reset:
- state=IDLE; pc=0; cells=0; busy=0; done=0; out_vec=0; err=0.
- Program memory is not reset; contents are undefined until written.

Reset mid-run: the asynchronous reset aborts immediately to the reset values above.

Program writes: with cfg_we=1 and busy=0, mem[cfg_addr] <= cfg_data. Writing while done=1 is allowed.

State machine:
- IDLE: start=1 -> LOAD. Latch len=prog_len (values > N_INSTR clamp to N_INSTR). Latch in_vec. err<=0.
- LOAD (1 cycle): cells[i]<=in_vec[i] for i<N_IN; all other cells<=0; pc<=0. Next state is EXEC if len>0, otherwise DONE.
- EXEC (one gate per cycle):
  - Fetch I=mem[pc] combinationally.
  - r = is_inv ? ~cell[src_a] : ~(cell[src_a] | cell[src_b]).
  - cell[dst] <= r, unless dst<N_IN: then the write is suppressed and err<=1.
  - pc<=pc+1. When pc==len-1 the next state is DONE.
- DONE (1 cycle): out_vec<=output cells (this includes the last gate's write); done=1; next state IDLE.

Ordering and hazards:
- Gate k sees all writes from gates 0..k-1; no hazard stalls.
- src==dst is legal and reads the old value.
- is_inv=1 ignores src_b.

Latency: start accepted at edge t; done is high in cycle t+2+len. A new start is accepted the cycle after done.

Ignored inputs: start while not IDLE is ignored (not queued); cfg_we while busy is ignored.

Index range: out-of-range indices (>=N_CELL) are impossible at default parameters. For non-power-of-2 N_CELL, reads return 0 and writes are dropped.

Decomposition:
- Package nor_seq_pkg holds:
  - state enum {IDLE, LOAD, EXEC, DONE};
  - the INSTR_W field offsets/widths;
  - helper constants OUT_BASE=N_CELL-N_OUT and IN_LAST=N_IN-1.
- Sub-module nor_cell_file: N_CELL flops with bulk load port, one write port and two combinational read ports; asynchronous active-low reset.
- The NOR evaluation and the FSM stay in the top module.

Test Plan:
- Program a 9-gate full_adder_1bit netlist (cells x0-3=0..3, n1..n6=4..9, G5/G6/G7=13/14/15): n2=nor(2,3); n1=nor(0,1); n4=nor(4,5); n3=nor(1,2); n5=inv(7); n6=nor(6,8); G5=nor(1,5); G6=nor(5,9); G7=nor(3,9). Use prog_len=9. Check in_vec=4'b0000 -> out_vec=3'b100; 4'b1111 -> 3'b000; 4'b0101 -> 3'b001. Each run: done exactly 11 cycles after start, busy high for 10 cycles.
- prog_len=0, start with in_vec=4'hF -> done 2 cycles after start, out_vec=3'b000, err=0.
- Gate with dst=2 (input cell) -> err=1 at done, cell 2 unchanged, other gates correct; err cleared on the next start.
- During EXEC: start pulses and cfg_we to slot 0 -> run unaffected, and mem[0] unchanged when read back via the next run's result.
- rst_n asserted in the middle of EXEC -> busy=0, done=0, out_vec=0 immediately; a rerun after reset produces the correct result.
- Back-to-back: start in the cycle after done with a new in_vec -> second result correct; out_vec holds the first result until the second done.
